// File: rtl/cache_memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_memory_controller
// Purpose  : Memory-side partner of the cache. Accepts 33-bit requests into a
//            small in-order FIFO and services them one at a time against an
//            internal word-addressed RAM with a fixed access latency. Read
//            data is returned with a one-cycle memory_response_ready pulse.
// Ports    : clock, reset (async, active-high)
//            memory_request        [32]=write, [31:16]=address, [15:0]=data
//            memory_request_ready  request valid this cycle
//            memory_response       read data, held until the next read
//            memory_response_ready one-cycle pulse with read data
//            busy                  FIFO non-empty or FSM not idle
//            overflow              sticky: a request was dropped
//            fifo_count            current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module cache_memory_controller #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int MEM_WORDS_LOG2 = 8,
    parameter int LATENCY        = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0]   memory_request,
    input  logic                             memory_request_ready,
    output logic [DATA_WIDTH-1:0]            memory_response,
    output logic                             memory_response_ready,
    output logic                             busy,
    output logic                             overflow,
    output logic [2:0]                       fifo_count
);

    // Only the write flag, the RAM-indexing address bits and the data are kept.
    localparam int         c_ENTRY_W  = 1 + MEM_WORDS_LOG2 + DATA_WIDTH;
    localparam int         c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [2:0] c_DEPTH    = 3'(FIFO_DEPTH);
    localparam int         c_WR_BIT   = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_done;
    logic [2:0]                  r_count;
    logic [c_PTR_W-1:0]          r_wr_ptr;
    logic [c_PTR_W-1:0]          r_rd_ptr;
    logic [c_ENTRY_W-1:0]        r_fifo_mem [FIFO_DEPTH];
    logic [c_ENTRY_W-1:0]        w_entry_in;
    logic [c_ENTRY_W-1:0]        w_head;
    logic [3:0]                  r_counter;
    logic                        r_op_write;
    logic [MEM_WORDS_LOG2-1:0]   r_op_addr;
    logic [DATA_WIDTH-1:0]       r_op_data;
    logic [DATA_WIDTH-1:0]       r_ram [2**MEM_WORDS_LOG2];

    // Upper address bits alias onto the RAM and are intentionally dropped.
    generate
        if (MEM_WORDS_LOG2 < ADDR_WIDTH) begin : g_addr_unused
            logic w_unused_addr;
            assign w_unused_addr = ^memory_request[c_WR_BIT-1 : DATA_WIDTH+MEM_WORDS_LOG2];
        end
    endgenerate

    assign w_entry_in = {memory_request[c_WR_BIT],
                         memory_request[DATA_WIDTH +: MEM_WORDS_LOG2],
                         memory_request[DATA_WIDTH-1:0]};
    assign w_head     = r_fifo_mem[r_rd_ptr];

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Pop only what was already stored: a same-edge push is not visible.
                if (r_count != 3'd0) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_counter == 4'd0) begin
                    w_done       = 1'b1;
                    w_next_state = r_op_write ? ST_IDLE : ST_RESPOND;
                end
            end
            ST_RESPOND: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // A full FIFO can still accept when the head leaves on the same edge.
    assign w_push = memory_request_ready && ((r_count != c_DEPTH) || w_pop);

    // ------------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= w_entry_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count  <= 3'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (memory_request_ready && !w_push) overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Operation registers, latency counter and read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_counter       <= 4'd0;
            r_op_write      <= 1'b0;
            r_op_addr       <= '0;
            r_op_data       <= '0;
            memory_response <= '0;
        end else begin
            if (w_pop) begin
                r_op_write <= w_head[c_ENTRY_W-1];
                r_op_addr  <= w_head[DATA_WIDTH +: MEM_WORDS_LOG2];
                r_op_data  <= w_head[DATA_WIDTH-1:0];
                r_counter  <= c_CNT_LOAD;
            end else if (r_state == ST_ACCESS && r_counter != 4'd0) begin
                r_counter <= r_counter - 4'd1;
            end
            if (w_done && !r_op_write) memory_response <= r_ram[r_op_addr];
        end
    end

    // RAM is deliberately not reset; reset only blocks a write on the abort edge.
    always_ff @(posedge clock) begin
        if (w_done && r_op_write && !reset) r_ram[r_op_addr] <= r_op_data;
    end

    assign memory_response_ready = (r_state == ST_RESPOND);
    assign busy                  = (r_count != 3'd0) || (r_state != ST_IDLE);
    assign fifo_count            = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_memory_controller
// Purpose  : Self-checking bench for cache_memory_controller. A transaction
//            level model (request queue, service timeline, array RAM) predicts
//            every output each cycle; directed scenarios are followed by a
//            randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_memory_controller;

    localparam int c_LAT   = 4;
    localparam int c_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [32:0] memory_request = '0;
    logic        memory_request_ready = 1'b0;
    logic [15:0] memory_response;
    logic        memory_response_ready;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    cache_memory_controller #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_WORDS_LOG2(8),
        .LATENCY(c_LAT), .FIFO_DEPTH(c_DEPTH)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .memory_request        (memory_request),
        .memory_request_ready  (memory_request_ready),
        .memory_response       (memory_response),
        .memory_response_ready (memory_response_ready),
        .busy                  (busy),
        .overflow              (overflow),
        .fifo_count            (fifo_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned  m_edge    = 0;
    int unsigned  m_done_at = 0;
    int unsigned  m_free_at = 0;
    logic [32:0]  m_q[$];
    logic [32:0]  m_cur;
    logic         m_cur_v   = 1'b0;
    logic [15:0]  m_ram [256];
    logic         m_ready   = 1'b0;
    logic [15:0]  m_resp    = '0;
    logic         m_ovf     = 1'b0;

    task automatic model_reset();
        m_q.delete();
        m_cur_v   = 1'b0;
        m_ready   = 1'b0;
        m_resp    = '0;
        m_ovf     = 1'b0;
        m_free_at = m_edge;
    endtask

    // One rising edge: completion of the op in flight, then a pop by a free
    // server of what was queued before this edge, then acceptance of the input.
    task automatic model_step(input logic v, input logic [32:0] r);
        int   cnt;
        logic pop_now;
        m_edge++;
        m_ready = 1'b0;
        if (m_cur_v && m_edge == m_done_at) begin
            if (m_cur[32]) m_ram[m_cur[23:16]] = m_cur[15:0];
            else begin
                m_resp  = m_ram[m_cur[23:16]];
                m_ready = 1'b1;
            end
            m_cur_v = 1'b0;
        end
        cnt     = m_q.size();
        pop_now = (cnt > 0) && !m_cur_v && (m_edge >= m_free_at);
        if (pop_now) begin
            m_cur     = m_q.pop_front();
            m_cur_v   = 1'b1;
            m_done_at = m_edge + c_LAT;
            m_free_at = m_edge + c_LAT + (m_cur[32] ? 1 : 2);
        end
        if (v) begin
            if (cnt < c_DEPTH || pop_now) m_q.push_back(r);
            else                          m_ovf = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check_value("ready",    32'(memory_response_ready), 32'(m_ready));
        check_value("response", 32'(memory_response),       32'(m_resp));
        check_value("count",    32'(fifo_count),            32'(m_q.size()));
        check_value("busy",     32'(busy),  32'((m_q.size() > 0) || m_cur_v || m_ready));
        check_value("overflow", 32'(overflow),              32'(m_ovf));
    endtask

    // Called at a falling edge: drive, clock, model, check at next falling edge.
    task automatic cycle(input logic v, input logic [32:0] r);
        memory_request_ready = v;
        memory_request       = r;
        @(posedge clock);
        model_step(v, r);
        @(negedge clock);
        memory_request_ready = 1'b0;
        check_outputs();
    endtask

    function automatic logic [32:0] wr(input logic [15:0] a, input logic [15:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [32:0] rd(input logic [15:0] a);
        return {1'b0, a, 16'h0000};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0);
    endtask

    initial begin
        logic [32:0] req;
        logic        v;

        // reset state
        repeat (2) @(negedge clock);
        check_outputs();
        reset = 1'b0;

        // give every RAM word a known value, paced so nothing is dropped
        for (int a = 0; a < 256; a++) begin
            cycle(1'b1, wr(16'(a), 16'($urandom)));
            idle(c_LAT);
        end
        idle(4);

        // write then read the same word
        cycle(1'b1, wr(16'h0012, 16'hBEEF));
        cycle(1'b1, rd(16'h0012));
        idle(14);
        check_value("beef_read", 32'(memory_response), 32'h0000BEEF);

        // four back-to-back reads of pre-written words
        for (int i = 1; i <= 4; i++) cycle(1'b1, wr(16'(i), 16'(i * 16'h1111)));
        idle(24);
        for (int i = 1; i <= 4; i++) cycle(1'b1, rd(16'(i)));
        idle(30);
        check_value("last_of_four", 32'(memory_response), 32'h00004444);
        check_value("idle_busy", 32'(busy), 32'd0);

        // aliasing: upper address bits are ignored
        cycle(1'b1, wr(16'h0105, 16'hA5A5));
        cycle(1'b1, rd(16'h0005));
        idle(14);
        check_value("alias_read", 32'(memory_response), 32'h0000A5A5);

        // six consecutive requests overflow a four-entry queue
        for (int i = 0; i < 6; i++) cycle(1'b1, wr(16'(8'h40 + i), 16'(16'hC000 + i)));
        idle(40);
        check_value("ovf_sticky", 32'(overflow), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, rd(16'(8'h40 + i)));
            idle(c_LAT + 1);
        end

        // reset two cycles into ACCESS aborts a queued write
        cycle(1'b1, wr(16'h0020, 16'h0BAD));
        idle(8);
        cycle(1'b1, wr(16'h0020, 16'h1234));
        idle(2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_outputs();
        cycle(1'b1, rd(16'h0020));
        idle(8);
        check_value("abort_kept", 32'(memory_response), 32'h00000BAD);

        // full queue while IDLE, push on the same edge as the pop
        cycle(1'b1, rd(16'h0001));
        for (int i = 0; i < 4; i++) cycle(1'b1, wr(16'(8'h60 + i), 16'(16'h6000 + i)));
        idle(2);
        cycle(1'b1, wr(16'h0064, 16'h6004));
        check_value("full_pop_count", 32'(fifo_count), 32'd4);
        check_value("full_pop_ovf",   32'(overflow),   32'd0);
        idle(40);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 2) == 0);
            req = {1'($urandom), 16'($urandom), 16'($urandom)};
            cycle(v, req);
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_memory_controller.md
Name: cache_memory_controller

Overview:
- Downstream neighbour of the cache: consumes the cache's 33-bit memory_request stream and returns 16-bit read data on memory_response / memory_response_ready.
- Buffers requests in a small in-order FIFO, services them one at a time against an internal word-addressed RAM with a fixed, parameterised access latency.
- Lets the cache be exercised end-to-end with realistic miss latency and back-to-back traffic.

Parameters:
- ADDR_WIDTH, 16, request address width.
- DATA_WIDTH, 16, memory word width.
- MEM_WORDS_LOG2, 8, log2 of internal RAM depth; the low MEM_WORDS_LOG2 address bits are used.
- LATENCY, 4, access cycles per request (legal range 1..15).
- FIFO_DEPTH, 4, request queue entries (power of two).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- memory_request  input  33  [32]=write, [31:16]=address, [15:0]=write data (ignored on reads).
- memory_request_ready  input  1  memory_request valid this cycle.
- memory_response  output  16  read data.
- memory_response_ready  output  1  one-cycle pulse; memory_response valid.
- busy  output  1  high when FIFO is non-empty or state is not IDLE.
- overflow  output  1  sticky; a request was dropped.
- fifo_count  output  3  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset: memory_response=0, memory_response_ready=0, overflow=0, fifo_count=0, busy=0, state=IDLE, latency counter=0. RAM contents are not reset and are preserved across reset.
- Enqueue: on a rising edge with memory_request_ready=1, the request is pushed if fifo_count<FIFO_DEPTH, or if fifo_count==FIFO_DEPTH and a pop occurs on the same edge. Otherwise the request is dropped, overflow is set to 1, and overflow stays set until reset.
- There is no backpressure to the cache. The queue order is strict FIFO and the pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, ACCESS and RESPOND.
- IDLE: if the FIFO is non-empty, pop the head into the op registers (write flag, address[MEM_WORDS_LOG2-1:0], data), load counter=LATENCY-1, then go to ACCESS. A request pushed on an edge cannot be popped on that same edge.
- ACCESS: if counter!=0, decrement it. If counter==0:
  - write: RAM[addr] <= data, go to IDLE.
  - read: latch RAM[addr] into memory_response, go to RESPOND.
- RESPOND: memory_response_ready=1 for exactly this cycle, then go to IDLE. memory_response holds its value until the next read response.
- Timing, with request accepted at edge N:
  - read: memory_response_ready is high during the cycle after edge N+LATENCY+1, i.e. LATENCY+2 cycles.
  - write: RAM is updated at edge N+LATENCY+1.
  - Minimum spacing between serviced reads is LATENCY+2 cycles; between writes it is LATENCY+1 cycles.
- Writes produce no response.
- Ordering: a read after a write to the same address always returns the new data, because the FIFO is in-order.
- Address bits above MEM_WORDS_LOG2 are ignored, so addresses alias modulo 2^MEM_WORDS_LOG2.
- Reset asserted mid-operation: the in-flight op is aborted with no RAM write and no response, the FIFO is flushed, and all outputs take their reset values immediately (asynchronously).
- busy is derived combinationally from FIFO occupancy and state.

Test Plan:
- Write 0x0012 <- 0xBEEF, then read 0x0012 (LATENCY=4) -> memory_response_ready pulses once, 6 cycles after read acceptance, with memory_response=0xBEEF; no pulse for the write.
- Four back-to-back reads of pre-written addresses 0x01..0x04 (data 0x1111..0x4444) -> four single-cycle pulses, in order, spaced exactly 6 cycles apart; fifo_count peaks at 3 or 4; busy falls after the last pulse.
- Six consecutive request cycles (FIFO_DEPTH=4) -> overflow=1 and stays set; exactly the accepted requests are serviced; the dropped ones leave the RAM unchanged.
- Write 0x0105 <- 0xA5A5, then read 0x0005 (MEM_WORDS_LOG2=8) -> returns 0xA5A5 (aliasing).
- Queue a write 0x0020 <- 0x1234, then assert reset two cycles into ACCESS -> all outputs 0 immediately, fifo_count=0; a subsequent read of 0x0020 returns the prior value, not 0x1234.
- FIFO full with state IDLE, push on the same edge as the pop -> request accepted, overflow stays 0, fifo_count remains 4.
